// File: rtl/cgra_sram_req_adapter.sv
// Valid/ready front-end for the CGRA SRAM bank: request strobes, read response FIFO, retention sequencing.
// Optional power-on zero sweep of the bank is compiled in with CGRA_SRAM_INIT_EN.
module cgra_sram_req_adapter #(
    parameter int NumWords   = 1024,
    parameter int AddrWidth  = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int RspDepth   = 2,
    parameter int WakeCycles = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [31:0]          req_wdata_i,
    input  logic [3:0]           req_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_rdata_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [31:0]          sram_wdata_o,
    output logic [3:0]           sram_be_o,
    input  logic [31:0]          sram_rdata_i,
    output logic                 sram_set_retentive_no,
    input  logic                 ret_req_i,
    output logic                 ret_ack_o,
    output logic                 init_done_o
);

    localparam int CntW  = $clog2(RspDepth + 2);
    localparam int PtrW  = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int WakeW = (WakeCycles > 1) ? $clog2(WakeCycles) : 1;

    localparam logic [CntW-1:0]  DepthC   = CntW'(RspDepth);
    localparam logic [PtrW-1:0]  PtrLast  = PtrW'(RspDepth - 1);
    localparam logic [WakeW-1:0] WakeLoad = WakeW'(WakeCycles - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_ACTIVE,
        ST_DRAIN,
        ST_RETENTION,
        ST_WAKE
    } state_e;

`ifdef CGRA_SRAM_INIT_EN
    localparam state_e ResetState = ST_INIT;
    localparam logic [AddrWidth-1:0] AddrLast = AddrWidth'(NumWords - 1);
`else
    localparam state_e ResetState = ST_ACTIVE;
`endif

    state_e state_q, state_d;

    logic [WakeW-1:0] wake_q, wake_d;
    logic             rd_pending_q, rd_pending_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [31:0]      mem_q [RspDepth];
    logic [31:0]      mem_d [RspDepth];

`ifdef CGRA_SRAM_INIT_EN
    logic [AddrWidth-1:0] init_addr_q, init_addr_d;
`endif

    logic            push;
    logic            pop;
    logic            empty;
    logic [CntW-1:0] credit;
    logic            read_ok;
    logic            active_open;
    logic            req_fire;
    logic            rd_fire;

    assign empty       = (cnt_q == '0);
    assign rsp_valid_o = ~empty;
    assign rsp_rdata_o = mem_q[rptr_q];
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign push        = rd_pending_q;

    // Credits count both buffered and in-flight reads so the FIFO never overflows.
    assign credit  = cnt_q + CntW'(rd_pending_q) - CntW'(pop);
    assign read_ok = (credit < DepthC);

    assign active_open = (state_q == ST_ACTIVE) & ~ret_req_i;
    assign req_ready_o = active_open & (req_we_i | read_ok);
    assign req_fire    = req_valid_i & req_ready_o;
    assign rd_fire     = req_fire & ~req_we_i;

    assign ret_ack_o             = (state_q == ST_RETENTION);
    assign sram_set_retentive_no = (state_q != ST_RETENTION);
    assign init_done_o           = (state_q != ST_INIT);

    always_comb begin
        sram_req_o   = req_fire;
        sram_we_o    = req_we_i;
        sram_addr_o  = req_addr_i;
        sram_wdata_o = req_wdata_i;
        sram_be_o    = req_be_i;
`ifdef CGRA_SRAM_INIT_EN
        // Sweep strobes are held off while reset is asserted.
        if (state_q == ST_INIT) begin
            sram_req_o   = rst_ni;
            sram_we_o    = 1'b1;
            sram_addr_o  = init_addr_q;
            sram_wdata_o = 32'h0;
            sram_be_o    = 4'hF;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        wake_d  = wake_q;
`ifdef CGRA_SRAM_INIT_EN
        init_addr_d = init_addr_q;
`endif
        unique case (state_q)
            ST_INIT: begin
`ifdef CGRA_SRAM_INIT_EN
                init_addr_d = init_addr_q + 1'b1;
                if (init_addr_q == AddrLast) begin
                    state_d = ST_ACTIVE;
                end
`else
                state_d = ST_ACTIVE;
`endif
            end
            ST_ACTIVE: begin
                if (ret_req_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!ret_req_i) begin
                    state_d = ST_ACTIVE;
                end else if (!rd_pending_q && empty) begin
                    state_d = ST_RETENTION;
                end
            end
            ST_RETENTION: begin
                if (!ret_req_i) begin
                    state_d = ST_WAKE;
                    wake_d  = WakeLoad;
                end
            end
            ST_WAKE: begin
                // A renewed retention request is honoured from ACTIVE once wake completes.
                if (wake_q == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    wake_d = wake_q - 1'b1;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_comb begin
        mem_d        = mem_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        rd_pending_d = rd_fire;
        if (push) begin
            mem_d[wptr_q] = sram_rdata_i;
            wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + 1'b1;
        end
        cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ResetState;
            wake_q       <= '0;
            rd_pending_q <= 1'b0;
            cnt_q        <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
        end else begin
            state_q      <= state_d;
            wake_q       <= wake_d;
            rd_pending_q <= rd_pending_d;
            cnt_q        <= cnt_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
        end
    end

`ifdef CGRA_SRAM_INIT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_addr_q <= '0;
        end else begin
            init_addr_q <= init_addr_d;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && !pop && (cnt_q == DepthC)));

endmodule

// File: tb/tb_cgra_sram_req_adapter.sv
// Self-checking bench for cgra_sram_req_adapter: vector table, scoreboard of read data, retention/reset sequences.
// Exercises the CGRA_SRAM_INIT_EN sweep when that macro is defined.
module tb_cgra_sram_req_adapter;

    localparam int NW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int WAKE  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic [3:0]    req_be = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic          sram_req;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [3:0]    sram_be;
    logic [31:0]   sram_rdata = '0;
    logic          sram_ret_n;
    logic          ret_req = 1'b0;
    logic          ret_ack;
    logic          init_done;

    int checks = 0;
    int failures = 0;
    int sweep_cnt = 0;
    int sweep_bad = 0;

    logic [31:0] sb [$];

    always #5 clk = ~clk;

    cgra_sram_req_adapter #(
        .NumWords  (NW),
        .RspDepth  (DEPTH),
        .WakeCycles(WAKE)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .req_valid_i          (req_valid),
        .req_ready_o          (req_ready),
        .req_we_i             (req_we),
        .req_addr_i           (req_addr),
        .req_wdata_i          (req_wdata),
        .req_be_i             (req_be),
        .rsp_valid_o          (rsp_valid),
        .rsp_ready_i          (rsp_ready),
        .rsp_rdata_o          (rsp_rdata),
        .sram_req_o           (sram_req),
        .sram_we_o            (sram_we),
        .sram_addr_o          (sram_addr),
        .sram_wdata_o         (sram_wdata),
        .sram_be_o            (sram_be),
        .sram_rdata_i         (sram_rdata),
        .sram_set_retentive_no(sram_ret_n),
        .ret_req_i            (ret_req),
        .ret_ack_o            (ret_ack),
        .init_done_o          (init_done)
    );

    // Bank model: latency-1 reads, byte-enabled writes, non-zero fill.
    logic [31:0] sram_mem [NW];
    logic        mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < NW; i++) sram_mem[i] <= 32'hA5A5_0000 | i;
            mem_init <= 1'b1;
        end else if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", rsp_rdata, 32'hXXXX_XXXX);
            end else begin
                check("rsp_data", rsp_rdata, sb.pop_front());
            end
        end
        if (rst_n && !init_done && sram_req) begin
            if (!sram_we || sram_wdata != 32'h0 || sram_be != 4'hF ||
                int'(sram_addr) != (sweep_cnt % NW))
                sweep_bad++;
            sweep_cnt++;
        end
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
        logic          exp_ready;
        logic [31:0]   exp_rdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                                input logic [3:0] be, input logic [31:0] exp);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.be = be;
        v.exp_ready = 1'b1; v.exp_rdata = exp;
        return v;
    endfunction

    task automatic set_req(input logic v, input logic we, input logic [AW-1:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        @(posedge clk); #1;
        req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int n;
        logic seen;

        tbl.push_back(mk(1, 5'h10, 32'hDEADBEEF, 4'hF, 0));
        tbl.push_back(mk(0, 5'h10, 0, 0, 32'hDEADBEEF));
        tbl.push_back(mk(1, 5'h10, 32'h11223344, 4'b0101, 0));
        tbl.push_back(mk(0, 5'h10, 0, 0, 32'hDE22BE44));
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(1, AW'(i), 32'hC0DE_0000 + i, 4'hF, 0));
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(0, AW'(i), 0, 0, 32'hC0DE_0000 + i));
`ifdef CGRA_SRAM_INIT_EN
        tbl.push_back(mk(0, 5'd20, 0, 0, 32'h0));
`endif

        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_ret_ack", ret_ack, 0);
        check("rst_ret_n", sram_ret_n, 1);
        check("rst_sram_req", sram_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef CGRA_SRAM_INIT_EN
        repeat (NW - 1) @(posedge clk);
        #1 check("init_early", init_done, 0);
        @(posedge clk);
        #1 check("init_done_at_nw", init_done, 1);
        check("sweep_count", sweep_cnt, NW);
        check("sweep_fields", sweep_bad, 0);
`else
        #1 check("init_done_now", init_done, 1);
        check("idle_sram_req", sram_req, 0);
`endif

        foreach (tbl[i]) begin
            set_req(1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be);
            @(negedge clk);
            check($sformatf("tbl_ready_%0d", i), req_ready, tbl[i].exp_ready);
            if (req_ready && !tbl[i].we) sb.push_back(tbl[i].exp_rdata);
        end
        set_req(0, 0, 0, 0, 0);
        wait_drain();

        set_req(1, 0, 5'h10, 0, 0);
        @(negedge clk);
        check("lat_accept", req_ready, 1);
        sb.push_back(32'hDE22BE44);
        set_req(0, 0, 0, 0, 0);
        @(negedge clk);
        check("lat_cycle1", rsp_valid, 0);
        @(negedge clk);
        check("lat_cycle2", rsp_valid, 1);
        wait_drain();

        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(1, 0, AW'(i + 1), 0, 0);
            @(negedge clk);
            check($sformatf("bp_read_%0d", i), req_ready, (i < DEPTH) ? 1 : 0);
            if (req_ready) sb.push_back(32'hC0DE_0000 + i + 1);
        end
        set_req(1, 1, 5'd9, 32'h0000_0009, 4'hF);
        @(negedge clk);
        check("bp_write_ready", req_ready, 1);
        set_req(0, 0, 0, 0, 0);
        rsp_ready = 1'b1;
        wait_drain();

        rsp_ready = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            set_req(1, 0, AW'(i), 0, 0);
            @(negedge clk);
            check("ret_pre_read", req_ready, 1);
            if (req_ready) sb.push_back(32'hC0DE_0000 + i);
        end
        set_req(1, 0, 5'd3, 0, 0);
        ret_req = 1'b1;
        @(negedge clk);
        check("ret_no_accept", req_ready, 0);
        repeat (3) @(negedge clk);
        check("ret_hold_ack", ret_ack, 0);
        check("ret_hold_ready", req_ready, 0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 12) begin
            @(negedge clk);
            n++;
            if (ret_ack) seen = 1'b1;
        end
        check("ret_ack_rise", seen, 1);
        check("ret_after_pop", sb.size(), 0);
        check("ret_pin", sram_ret_n, 0);
        check("ret_sram_req", sram_req, 0);
        set_req(0, 0, 0, 0, 0);
        ret_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("wake_ack_drop", ret_ack, 0);
        check("wake_pin", sram_ret_n, 1);
        n = 0;
        while (!req_ready && n < 12) begin
            n++;
            @(negedge clk);
        end
        check("wake_cycles", n, WAKE);
        set_req(1, 0, 5'h10, 0, 0);
        @(negedge clk);
        check("post_ret_accept", req_ready, 1);
        if (req_ready) sb.push_back(32'hDE22BE44);
        set_req(1, 0, 5'd9, 0, 0);
        @(negedge clk);
        if (req_ready) sb.push_back(32'h0000_0009);
        set_req(0, 0, 0, 0, 0);
        wait_drain();

        rsp_ready = 1'b0;
        set_req(1, 0, 5'd4, 0, 0);
        @(negedge clk);
        check("rst_read_accept", req_ready, 1);
        set_req(0, 0, 0, 0, 0);
        ret_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_buffered", rsp_valid, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_ret_n", sram_ret_n, 1);
        check("rst_mid_ret_ack", ret_ack, 0);
        ret_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        n = 0;
        while (!init_done && n < NW + 10) begin
            @(negedge clk);
            n++;
        end
        check("rst_init_done", init_done, 1);
        repeat (3) @(negedge clk);
        check("rst_rsp_lost", rsp_valid, 0);
        set_req(1, 0, 5'h10, 0, 0);
        @(negedge clk);
`ifdef CGRA_SRAM_INIT_EN
        if (req_ready) sb.push_back(32'h0);
`else
        if (req_ready) sb.push_back(32'hDE22BE44);
`endif
        check("rst_after_accept", req_ready, 1);
        set_req(0, 0, 0, 0, 0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
